// File: rtl/sram_bist_engine_if.sv
// Memory-side bus between the BIST engine and a synchronous single-port SRAM.
// The engine owns address/write controls; the SRAM returns registered read data.
interface sram_bist_engine_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 4
);
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport master (output mem_we, output mem_addr, output mem_wdata, input mem_rdata);
   modport slave  (input mem_we, input mem_addr, input mem_wdata, output mem_rdata);
endinterface

// File: rtl/sram_bist_engine.sv
// SRAM built-in self-test engine: blanket, checkerboard and March C- algorithms with
// first-fail capture and a saturating mismatch counter; functional access passes through when idle.
//
// state      | meaning
// IDLE       | waiting for start; memory bus follows the functional port
// WRITE      | one write op at addr_q for the current element
// READ_ISSUE | read address presented to the SRAM
// READ_CMP   | registered read data compared against the expected word
// NEXT       | reserved encoding; address/element advance is folded into the last op cycle
// DONE       | one-cycle completion pulse, busy low
module sram_bist_engine #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 4,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [1:0]        mode,
   input  logic              fn_we,
   input  logic [ADDR_W-1:0] fn_addr,
   input  logic [DATA_W-1:0] fn_wdata,
   output logic [DATA_W-1:0] fn_rdata,
   sram_bist_engine_if.master mem,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [CNT_W-1:0]  fail_count,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [DATA_W-1:0] fail_data
);

   typedef enum logic [2:0] {IDLE, WRITE, READ_ISSUE, READ_CMP, NEXT, DONE} state_t;

   // one March element: optional read (with polarity), optional write, direction, final flag
   typedef struct packed {
      logic rd;
      logic rpol;
      logic wr;
      logic wpol;
      logic down;
      logic last;
   } elem_t;

   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

   function automatic elem_t elem_desc(input logic [1:0] md, input logic [2:0] idx);
      elem_t d;
      d = elem_t'(6'b000001);
      if (md == 2'd2) begin
         case (idx)
            3'd0:    d = elem_t'(6'b001000);
            3'd1:    d = elem_t'(6'b101100);
            3'd2:    d = elem_t'(6'b111000);
            3'd3:    d = elem_t'(6'b101110);
            3'd4:    d = elem_t'(6'b111010);
            3'd5:    d = elem_t'(6'b100001);
            default: d = elem_t'(6'b000001);
         endcase
      end else begin
         case (idx)
            3'd0:    d = elem_t'(6'b001000);
            3'd1:    d = elem_t'(6'b100000);
            3'd2:    d = elem_t'(6'b001100);
            3'd3:    d = elem_t'(6'b110001);
            default: d = elem_t'(6'b000001);
         endcase
      end
      return d;
   endfunction

   // checkerboard base is ...0101 at even addresses, inverted at odd; pol=1 inverts the word
   function automatic logic [DATA_W-1:0] pattern(input logic [1:0] md, input logic pol,
                                                 input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] w;
      for (int i = 0; i < DATA_W; i++) w[i] = (md == 2'd1) && (((i % 2) == 0) != a[0]);
      return pol ? ~w : w;
   endfunction

   state_t            state_q, state_d;
   logic [1:0]        mode_q;
   logic [2:0]        elem_q, elem_d;
   logic [ADDR_W-1:0] addr_q, addr_d, addr_end;
   logic [CNT_W-1:0]  fail_count_q;
   logic [ADDR_W-1:0] fail_addr_q;
   logic [DATA_W-1:0] fail_data_q;
   logic              pass_q;
   logic              accept, finish, step, mismatch;
   elem_t             cur, nxt;
   logic [DATA_W-1:0] eng_wdata, exp_rdata;

   assign cur       = elem_desc(mode_q, elem_q);
   assign nxt       = elem_desc(mode_q, elem_q + 3'd1);
   assign addr_end  = cur.down ? '0 : '1;
   assign eng_wdata = pattern(mode_q, cur.wpol, addr_q);
   assign exp_rdata = pattern(mode_q, cur.rpol, addr_q);
   assign mismatch  = (state_q == READ_CMP) && (mem.mem_rdata != exp_rdata);

   assign busy = (state_q == WRITE) || (state_q == READ_ISSUE) || (state_q == READ_CMP);
   assign done = (state_q == DONE);

   always_comb begin
      state_d = state_q;
      elem_d  = elem_q;
      addr_d  = addr_q;
      accept  = 1'b0;
      finish  = 1'b0;
      step    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               accept  = 1'b1;
               elem_d  = 3'd0;
               addr_d  = '0;
               state_d = (mode == 2'd3) ? DONE : WRITE;
            end
         end
         WRITE:      step = 1'b1;
         READ_ISSUE: state_d = READ_CMP;
         READ_CMP: begin
            if (cur.wr) state_d = WRITE;
            else        step = 1'b1;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // last op at this address: move on with no idle cycle between addresses or elements
      if (step) begin
         if (addr_q == addr_end) begin
            if (cur.last) begin
               state_d = DONE;
               finish  = 1'b1;
            end else begin
               elem_d  = elem_q + 3'd1;
               addr_d  = nxt.down ? '1 : '0;
               state_d = nxt.rd ? READ_ISSUE : WRITE;
            end
         end else begin
            addr_d  = cur.down ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
            state_d = cur.rd ? READ_ISSUE : WRITE;
         end
      end
      if (busy && abort) begin
         state_d = IDLE;
         finish  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         elem_q  <= '0;
         addr_q  <= '0;
         mode_q  <= '0;
      end else begin
         state_q <= state_d;
         elem_q  <= elem_d;
         addr_q  <= addr_d;
         if (accept) mode_q <= mode;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fail_count_q <= '0;
         fail_addr_q  <= '0;
         fail_data_q  <= '0;
         pass_q       <= 1'b0;
      end else if (accept) begin
         fail_count_q <= '0;
         fail_addr_q  <= '0;
         fail_data_q  <= '0;
         pass_q       <= 1'b0;
      end else begin
         if (mismatch) begin
            if (fail_count_q != CNT_MAX) fail_count_q <= fail_count_q + CNT_ONE;
            if (fail_count_q == '0) begin
               fail_addr_q <= addr_q;
               fail_data_q <= mem.mem_rdata;
            end
         end
         // the final compare lands on the same edge, so fold it in directly
         if (finish) pass_q <= (fail_count_q == '0) && !mismatch;
      end
   end

   assign mem.mem_we    = busy ? (state_q == WRITE) : fn_we;
   assign mem.mem_addr  = busy ? addr_q : fn_addr;
   assign mem.mem_wdata = busy ? eng_wdata : fn_wdata;
   assign fn_rdata      = mem.mem_rdata;

   assign pass       = pass_q;
   assign fail_count = fail_count_q;
   assign fail_addr  = fail_addr_q;
   assign fail_data  = fail_data_q;

endmodule

// File: tb/tb_sram_bist_engine.sv
// Self-checking bench for sram_bist_engine with a stuck-at SRAM model and an
// element-level algorithm model that predicts cycles, writes and fail results.
module tb_sram_bist_engine;
   localparam int AW = 2;
   localparam int DW = 4;
   localparam int CW = 3;
   localparam int N  = 4;
   localparam int CMAX = 7;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [1:0]    mode = 2'd0;
   logic          fn_we = 1'b0;
   logic [AW-1:0] fn_addr = '0;
   logic [DW-1:0] fn_wdata = '0;
   logic [DW-1:0] fn_rdata;
   logic          busy, done, pass;
   logic [CW-1:0] fail_count;
   logic [AW-1:0] fail_addr;
   logic [DW-1:0] fail_data;

   sram_bist_engine_if #(.ADDR_W(AW), .DATA_W(DW)) mif ();

   sram_bist_engine #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
      .fn_we(fn_we), .fn_addr(fn_addr), .fn_wdata(fn_wdata), .fn_rdata(fn_rdata),
      .mem(mif), .busy(busy), .done(done), .pass(pass),
      .fail_count(fail_count), .fail_addr(fail_addr), .fail_data(fail_data)
   );

   always #5 clk = ~clk;

   // SRAM with per-address stuck-at-0 / stuck-at-1 masks applied on read
   logic [DW-1:0] sram [N];
   logic [DW-1:0] sa0 [N];
   logic [DW-1:0] sa1 [N];
   always @(posedge clk) begin
      if (mif.mem_we) sram[mif.mem_addr] <= mif.mem_wdata;
      mif.mem_rdata <= (sram[mif.mem_addr] & ~sa0[mif.mem_addr]) | sa1[mif.mem_addr];
   end

   int busy_cnt = 0, done_cnt = 0, we_cnt = 0;
   logic [AW+DW-1:0] wr_q[$];
   always @(negedge clk) begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (mif.mem_we) we_cnt++;
      if (busy && mif.mem_we) wr_q.push_back({mif.mem_addr, mif.mem_wdata});
   end

   int tests_run = 0, fails = 0;
   int b_busy, b_done, b_we, b_wr, run_lat;
   int exp_cycles, exp_cnt, exp_faddr, exp_fdata;
   bit exp_pass;
   logic [AW+DW-1:0] exp_wr[$];

   function automatic logic [DW-1:0] word(input int md, input int pol, input int a);
      logic [DW-1:0] w;
      if (md == 1) w = (a % 2 == 0) ? 4'b0101 : 4'b1010;
      else         w = 4'b0000;
      return (pol != 0) ? ~w : w;
   endfunction

   task automatic model_run(input int md);
      logic [DW-1:0] m [N];
      logic [DW-1:0] v, wd;
      int e_rd[6], e_rp[6], e_wr[6], e_wp[6], e_dn[6];
      int nel, a, mism;
      if (md == 2) begin
         nel = 6;
         e_rd = '{0, 1, 1, 1, 1, 1}; e_rp = '{0, 0, 1, 0, 1, 0};
         e_wr = '{1, 1, 1, 1, 1, 0}; e_wp = '{0, 1, 0, 1, 0, 0};
         e_dn = '{0, 0, 0, 1, 1, 0};
      end else begin
         nel = 4;
         e_rd = '{0, 1, 0, 1, 0, 0}; e_rp = '{0, 0, 0, 1, 0, 0};
         e_wr = '{1, 0, 1, 0, 0, 0}; e_wp = '{0, 0, 1, 0, 0, 0};
         e_dn = '{0, 0, 0, 0, 0, 0};
      end
      exp_wr.delete();
      exp_cycles = 0; mism = 0; exp_faddr = 0; exp_fdata = 0;
      for (int e = 0; e < nel; e++) begin
         for (int k = 0; k < N; k++) begin
            a = (e_dn[e] != 0) ? (N - 1 - k) : k;
            if (e_rd[e] != 0) begin
               exp_cycles += 2;
               v = (m[a] & ~sa0[a]) | sa1[a];
               if (v !== word(md, e_rp[e], a)) begin
                  if (mism == 0) begin exp_faddr = a; exp_fdata = int'(v); end
                  mism++;
               end
            end
            if (e_wr[e] != 0) begin
               exp_cycles += 1;
               wd = word(md, e_wp[e], a);
               m[a] = wd;
               exp_wr.push_back({AW'(a), wd});
            end
         end
      end
      exp_cnt  = (mism > CMAX) ? CMAX : mism;
      exp_pass = (mism == 0);
   endtask

   task automatic clear_faults();
      for (int a = 0; a < N; a++) begin sa0[a] = '0; sa1[a] = '0; end
   endtask

   task automatic random_faults();
      for (int a = 0; a < N; a++) begin
         sa1[a] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
         sa0[a] = ($urandom_range(0, 2) == 0) ? (4'($urandom_range(0, 15)) & ~sa1[a]) : 4'h0;
      end
   endtask

   task automatic do_run(input logic [1:0] md, input bit mid_start, output bit timed_out);
      @(negedge clk);
      b_busy = busy_cnt; b_done = done_cnt; b_we = we_cnt; b_wr = wr_q.size();
      mode = md; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      mode = 2'($urandom_range(0, 3));
      timed_out = 1'b1;
      run_lat = -1;
      for (int i = 0; i < 200; i++) begin
         if (done) begin timed_out = 1'b0; run_lat = i; break; end
         @(negedge clk);
         start = (mid_start && i == 10);
      end
      start = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      #12;
      tests_run++;
      if ({busy, done, pass, fail_count, fail_addr, fail_data} !== '0) begin
         fails++;
         $display("FAIL reset_outputs: got busy=%0b done=%0b pass=%0b cnt=%0d addr=%0d data=%0h, need all 0",
                  busy, done, pass, fail_count, fail_addr, fail_data);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_blanket();
      bit to;
      clear_faults();
      do_run(2'd0, 1'b0, to);
      tests_run++;
      if (to) begin fails++; $display("FAIL blanket_timeout: got no done, need done"); end
      tests_run++;
      if (busy_cnt - b_busy != 24) begin
         fails++; $display("FAIL blanket_busy: got %0d need 24", busy_cnt - b_busy);
      end
      tests_run++;
      if (done_cnt - b_done != 1) begin
         fails++; $display("FAIL blanket_done: got %0d pulses need 1", done_cnt - b_done);
      end
      tests_run++;
      if (pass !== 1'b1 || fail_count !== '0) begin
         fails++; $display("FAIL blanket_result: got pass=%0b cnt=%0d need pass=1 cnt=0", pass, fail_count);
      end
   endtask

   task automatic test_march_fault();
      bit to;
      clear_faults();
      sa1[2] = 4'b0001;
      do_run(2'd2, 1'b0, to);
      tests_run++;
      if (busy_cnt - b_busy != 60) begin
         fails++; $display("FAIL march_busy: got %0d need 60", busy_cnt - b_busy);
      end
      tests_run++;
      if (pass !== 1'b0 || fail_count !== 3'd3) begin
         fails++; $display("FAIL march_result: got pass=%0b cnt=%0d need pass=0 cnt=3", pass, fail_count);
      end
      tests_run++;
      if (fail_addr !== 2'd2 || fail_data !== 4'b0001) begin
         fails++; $display("FAIL march_first: got addr=%0d data=%0h need addr=2 data=1", fail_addr, fail_data);
      end
      clear_faults();
   endtask

   task automatic test_checkerboard();
      bit to;
      clear_faults();
      do_run(2'd1, 1'b1, to);
      tests_run++;
      if (busy_cnt - b_busy != 24 || done_cnt - b_done != 1) begin
         fails++;
         $display("FAIL checker_cycles: got busy=%0d done=%0d need busy=24 done=1",
                  busy_cnt - b_busy, done_cnt - b_done);
      end
      tests_run++;
      if (pass !== 1'b1) begin fails++; $display("FAIL checker_pass: got %0b need 1", pass); end
      tests_run++;
      if (wr_q.size() - b_wr != 8) begin
         fails++; $display("FAIL checker_wr_count: got %0d need 8", wr_q.size() - b_wr);
      end else if (wr_q[b_wr] !== 6'b00_0101 || wr_q[b_wr+1] !== 6'b01_1010 ||
                   wr_q[b_wr+4] !== 6'b00_1010 || wr_q[b_wr+5] !== 6'b01_0101) begin
         fails++;
         $display("FAIL checker_wr_data: got %0h %0h %0h %0h need 05 1a 0a 15",
                  wr_q[b_wr], wr_q[b_wr+1], wr_q[b_wr+4], wr_q[b_wr+5]);
      end
   endtask

   task automatic test_reserved_mode();
      bit to;
      clear_faults();
      sa1[1] = 4'hF;
      do_run(2'd0, 1'b0, to);
      clear_faults();
      do_run(2'd3, 1'b0, to);
      tests_run++;
      if (run_lat != 0 || done_cnt - b_done != 1 || busy_cnt - b_busy != 0) begin
         fails++;
         $display("FAIL reserved_pulse: got lat=%0d done=%0d busy=%0d need 0 1 0",
                  run_lat, done_cnt - b_done, busy_cnt - b_busy);
      end
      tests_run++;
      if (fail_count !== '0) begin fails++; $display("FAIL reserved_cnt: got %0d need 0", fail_count); end
      do_run(2'd0, 1'b0, to);
      do_run(2'd3, 1'b0, to);
      tests_run++;
      if (pass !== 1'b0 || we_cnt - b_we != 0) begin
         fails++; $display("FAIL reserved_pass_we: got pass=%0b we=%0d need 0 0", pass, we_cnt - b_we);
      end
   endtask

   task automatic test_abort();
      bit to;
      int seen = 0;
      clear_faults();
      sa1[0] = 4'b0001;
      @(negedge clk);
      b_done = done_cnt;
      mode = 2'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 40 && seen < 10; i++) begin
         if (busy) seen++;
         if (seen < 10) @(negedge clk);
      end
      tests_run++;
      if (seen != 10) begin fails++; $display("FAIL abort_reach: got %0d busy cycles need 10", seen); end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      tests_run++;
      if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin
         fails++; $display("FAIL abort_state: got busy=%0b done=%0b pass=%0b need 0 0 0", busy, done, pass);
      end
      tests_run++;
      if (fail_count !== 3'd1 || fail_addr !== 2'd0 || fail_data !== 4'b0001) begin
         fails++;
         $display("FAIL abort_retain: got cnt=%0d addr=%0d data=%0h need 1 0 1", fail_count, fail_addr, fail_data);
      end
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      repeat (70) @(negedge clk);
      tests_run++;
      if (done_cnt - b_done != 0 || busy !== 1'b0) begin
         fails++; $display("FAIL abort_no_done: got done=%0d busy=%0b need 0 0", done_cnt - b_done, busy);
      end
      clear_faults();
      do_run(2'd2, 1'b0, to);
      tests_run++;
      if (busy_cnt - b_busy != 60 || pass !== 1'b1 || done_cnt - b_done != 1) begin
         fails++;
         $display("FAIL abort_rerun: got busy=%0d pass=%0b done=%0d need 60 1 1",
                  busy_cnt - b_busy, pass, done_cnt - b_done);
      end
   endtask

   task automatic test_reset_midrun();
      clear_faults();
      sa1[1] = 4'hF;
      @(negedge clk);
      b_done = done_cnt;
      mode = 2'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (25) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      tests_run++;
      if ({busy, done, pass, fail_count, fail_addr, fail_data} !== '0) begin
         fails++;
         $display("FAIL midrun_reset: got busy=%0b done=%0b pass=%0b cnt=%0d addr=%0d data=%0h, need all 0",
                  busy, done, pass, fail_count, fail_addr, fail_data);
      end
      @(negedge clk);
      rst_n = 1'b1;
      clear_faults();
      repeat (70) @(negedge clk);
      tests_run++;
      if (done_cnt - b_done != 0 || busy !== 1'b0) begin
         fails++; $display("FAIL midrun_no_done: got done=%0d busy=%0b need 0 0", done_cnt - b_done, busy);
      end
      fn_we = 1'b1; fn_addr = 2'd3; fn_wdata = 4'hA;
      @(negedge clk);
      fn_we = 1'b0;
      @(negedge clk);
      tests_run++;
      if (fn_rdata !== 4'hA) begin fails++; $display("FAIL fn_readback: got %0h need a", fn_rdata); end
   endtask

   task automatic test_saturation();
      bit to;
      for (int a = 0; a < N; a++) begin sa0[a] = '0; sa1[a] = 4'hF; end
      model_run(2);
      do_run(2'd2, 1'b0, to);
      tests_run++;
      if (fail_count !== CW'(exp_cnt) || exp_cnt != CMAX) begin
         fails++; $display("FAIL saturate_cnt: got %0d need %0d (max %0d)", fail_count, exp_cnt, CMAX);
      end
      tests_run++;
      if (fail_addr !== 2'd0 || fail_data !== 4'hF) begin
         fails++; $display("FAIL saturate_first: got addr=%0d data=%0h need 0 f", fail_addr, fail_data);
      end
      clear_faults();
   endtask

   task automatic test_random();
      bit to, bad;
      int md;
      for (int it = 0; it < 10; it++) begin
         md = $urandom_range(0, 2);
         random_faults();
         model_run(md);
         do_run(2'(md), 1'($urandom_range(0, 1)), to);
         tests_run++;
         if (to || busy_cnt - b_busy != exp_cycles || done_cnt - b_done != 1) begin
            fails++;
            $display("FAIL rand_cycles[%0d] mode=%0d: got busy=%0d done=%0d to=%0b need busy=%0d done=1",
                     it, md, busy_cnt - b_busy, done_cnt - b_done, to, exp_cycles);
         end
         tests_run++;
         if (pass !== exp_pass || fail_count !== CW'(exp_cnt)) begin
            fails++;
            $display("FAIL rand_result[%0d] mode=%0d: got pass=%0b cnt=%0d need pass=%0b cnt=%0d",
                     it, md, pass, fail_count, exp_pass, exp_cnt);
         end
         tests_run++;
         if (fail_addr !== AW'(exp_faddr) || fail_data !== DW'(exp_fdata)) begin
            fails++;
            $display("FAIL rand_first[%0d] mode=%0d: got addr=%0d data=%0h need addr=%0d data=%0h",
                     it, md, fail_addr, fail_data, exp_faddr, exp_fdata);
         end
         bad = (wr_q.size() - b_wr != exp_wr.size());
         if (!bad) for (int i = 0; i < exp_wr.size(); i++) if (wr_q[b_wr+i] !== exp_wr[i]) bad = 1'b1;
         tests_run++;
         if (bad) begin
            fails++;
            $display("FAIL rand_writes[%0d] mode=%0d: got %0d writes need %0d with matching addr/data",
                     it, md, wr_q.size() - b_wr, exp_wr.size());
         end
      end
      clear_faults();
   endtask

   initial begin
      clear_faults();
      test_reset();
      test_blanket();
      test_march_fault();
      test_checkerboard();
      test_reserved_mode();
      test_abort();
      test_reset_midrun();
      test_saturation();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete within 500000 time units");
      $fatal(1);
   end
endmodule
